key_draw_scheduler: RTL and testbench



---
 rtl/key_draw_scheduler_if.sv | 35 +++
 rtl/key_draw_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_key_draw_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_draw_scheduler_if.sv
// Pixel-write bus around the key draw scheduler: live and playback key state
// flow in, one VGA pixel write per cycle flows out toward vga_adapter.
interface key_draw_scheduler_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] keys;           // live key pressed, 1 = pressed
    logic [NUM_KEYS-1:0] playback_keys;  // recorder playback key active
    logic [7:0]          x;              // pixel x, 0..159
    logic [6:0]          y;              // pixel y, 0..119
    logic [2:0]          colour;         // {R,G,B}
    logic                plot;           // one pixel write per cycle while high
    logic                busy;           // a rectangle job is in SETUP or DRAW

    // Scheduler side: consumes key state, owns the pixel port.
    modport master (
        input  keys,
        input  playback_keys,
        output x,
        output y,
        output colour,
        output plot,
        output busy
    );

    // Switches / recorder / vga_adapter side.
    modport slave (
        output keys,
        output playback_keys,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  busy
    );
endinterface

// File: rtl/key_draw_scheduler.sv
// Key draw scheduler: keeps one on-screen rectangle per synth key in step with
// the live/playback state of that key. A key whose displayed state is stale
// (or that is flagged for a forced redraw) is pending; pending keys are granted
// round-robin and each grant repaints the whole rectangle, one pixel per cycle,
// through the single vga_adapter write port.
module key_draw_scheduler #(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W    = 32,
    parameter int KEY_H    = 40,
    parameter int KEY_X0   = 8,
    parameter int KEY_Y0   = 60,
    parameter int KEY_GAP  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    key_draw_scheduler_if.master  bus
);

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PX_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int PY_W  = (KEY_H > 1) ? $clog2(KEY_H) : 1;
    localparam int PITCH = KEY_W + KEY_GAP;

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(KEY_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(KEY_H - 1);

    typedef logic [IDX_W-1:0] key_idx_t;
    typedef logic [1:0]       key_state_t;  // {live, play}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    // Display colour for a {live, play} key state.
    function automatic logic [2:0] colour_map(input key_state_t s);
        case (s)
            2'b00:   colour_map = 3'b111;  // idle: white
            2'b10:   colour_map = 3'b100;  // live only: red
            2'b01:   colour_map = 3'b010;  // playback only: green
            default: colour_map = 3'b110;  // both: yellow
        endcase
    endfunction

    // Screen x of column col inside the rectangle of key k.
    function automatic logic [7:0] pixel_x(input key_idx_t k, input logic [PX_W-1:0] col);
        pixel_x = 8'(KEY_X0 + int'(k) * PITCH + int'(col));
    endfunction

    // Screen y of row row inside any rectangle.
    function automatic logic [6:0] pixel_y(input logic [PY_W-1:0] row);
        pixel_y = 7'(KEY_Y0 + int'(row));
    endfunction

    // Key after k in round-robin order.
    function automatic key_idx_t next_key(input key_idx_t k);
        next_key = key_idx_t'((int'(k) + 1) % NUM_KEYS);
    endfunction

    // Control state.
    state_t   state, state_next;
    key_idx_t rr_ptr, rr_next;
    key_idx_t grant, grant_next;

    // Per-key bookkeeping.
    key_state_t [NUM_KEYS-1:0] cur;    // inputs sampled on the last edge
    key_state_t [NUM_KEYS-1:0] drawn;  // state last committed to the screen
    logic       [NUM_KEYS-1:0] init;   // force-redraw flags, set by reset
    logic       [NUM_KEYS-1:0] pending;

    // Job datapath.
    logic [2:0]      job_colour, job_colour_next;
    logic [PX_W-1:0] px, px_next;
    logic [PY_W-1:0] py, py_next;
    logic            commit;

    // Next values of the registered pixel port.
    logic [7:0] x_next;
    logic [6:0] y_next;
    logic [2:0] colour_next;
    logic       plot_next;
    logic       busy_next;

    // Round-robin pick.
    logic     pick_valid;
    key_idx_t pick_idx;
    key_idx_t cand;

    // A key needs a repaint when what is on screen differs from its inputs,
    // or when reset has asked for every rectangle to be painted again.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            pending[i] = (cur[i] != drawn[i]) | init[i];
        end
    end

    // First pending key at or after rr_ptr, wrapping; scanning from the far
    // end lets the key closest to rr_ptr overwrite any earlier candidate.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            cand = key_idx_t'((int'(rr_ptr) + k) % NUM_KEYS);
            if (pending[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic and next values of the registered pixel port.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_next      = state;
        grant_next      = grant;
        rr_next         = rr_ptr;
        px_next         = px;
        py_next         = py;
        job_colour_next = job_colour;
        commit          = 1'b0;
        plot_next       = 1'b0;
        x_next          = '0;
        y_next          = '0;
        colour_next     = '0;

        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_idx;
                    state_next = ST_SETUP;
                end
            end

            // Commit the granted key's state and colour, then emit pixel (0,0).
            // Later input changes to this key leave the job's colour alone and
            // simply make the key pending again.
            ST_SETUP: begin
                commit          = 1'b1;
                job_colour_next = colour_map(cur[grant]);
                px_next         = '0;
                py_next         = '0;
                plot_next       = 1'b1;
                x_next          = pixel_x(grant, '0);
                y_next          = pixel_y('0);
                colour_next     = colour_map(cur[grant]);
                state_next      = ST_DRAW;
            end

            // px/py name the pixel currently on the port; advance in raster
            // order, and after the bottom-right pixel drop plot and hand the
            // round-robin pointer to the next key.
            ST_DRAW: begin
                if (px == PX_LAST && py == PY_LAST) begin
                    rr_next    = next_key(grant);
                    state_next = ST_IDLE;
                end else begin
                    if (px == PX_LAST) begin
                        px_next = '0;
                        py_next = py + 1'b1;
                    end else begin
                        px_next = px + 1'b1;
                    end
                    plot_next   = 1'b1;
                    x_next      = pixel_x(grant, px_next);
                    y_next      = pixel_y(py_next);
                    colour_next = job_colour;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // FSM state, job counters and the registered pixel port; reset aborts any
    // job in flight on the very next edge.
    always_ff @(posedge clock) begin
        // NOTE: registers are updated with <= so each one sees the pre-edge
        // value of every other register, independent of statement order.
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            job_colour <= '0;
            px         <= '0;
            py         <= '0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_next;
            grant      <= grant_next;
            job_colour <= job_colour_next;
            px         <= px_next;
            py         <= py_next;
            bus.x      <= x_next;
            bus.y      <= y_next;
            bus.colour <= colour_next;
            bus.plot   <= plot_next;
            bus.busy   <= busy_next;
        end
    end

    // Input sampling and per-key commit; reset marks every key for redraw.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the per-key tables are reset on purpose: a known drawn
            // state plus set init flags is what guarantees a full repaint.
            cur   <= '0;
            drawn <= '0;
            init  <= '1;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cur[i] <= {bus.keys[i], bus.playback_keys[i]};
            end
            if (commit) begin
                drawn[grant] <= cur[grant];
                init[grant]  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_draw_scheduler.sv
// Bench for key_draw_scheduler. A negedge monitor rebuilds every rectangle job
// from the pixel stream and paints a shadow framebuffer; directed steps check
// job order, colour, geometry, latency and reset, then random key activity is
// checked against the rule that, once quiet, each rectangle shows the colour
// of its key's inputs and nothing is drawn outside the rectangles.
module tb_key_draw_scheduler;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_W      = 32;
    localparam int KEY_H      = 40;
    localparam int KEY_X0     = 8;
    localparam int KEY_Y0     = 60;
    localparam int KEY_GAP    = 4;
    localparam int PITCH      = KEY_W + KEY_GAP;
    localparam int JOB_PIXELS = KEY_W * KEY_H;
    localparam int JOB_BUDGET = 3000;
    localparam int QUIET_BUDGET = 12000;

    typedef struct {
        int         key;
        logic [2:0] colour;
        int         pixels;
        int         raster_errs;
        int         first_x;
        int         first_y;
        int         last_x;
        int         last_y;
        int         start_cyc;
        int         end_cyc;
    } job_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [NUM_KEYS-1:0] mk = '0;  // live keys applied by the bench
    logic [NUM_KEYS-1:0] mp = '0;  // playback keys applied by the bench

    job_t       jobs[$];
    job_t       cur_job;
    bit         in_job = 1'b0;
    int         stray  = 0;
    int         mx, my;
    logic [2:0] fb [128][256];

    key_draw_scheduler_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    key_draw_scheduler #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W),
        .KEY_H    (KEY_H),
        .KEY_X0   (KEY_X0),
        .KEY_Y0   (KEY_Y0),
        .KEY_GAP  (KEY_GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #950000;
        $display("FAIL watchdog: run did not finish, observed cycle %0d, required finish", cyc);
        $fatal(1);
    end

    function automatic logic [2:0] colour_of(input logic live, input logic play);
        case ({live, play})
            2'b00:   return 3'b111;
            2'b10:   return 3'b100;
            2'b01:   return 3'b010;
            default: return 3'b110;
        endcase
    endfunction

    function automatic int base_x(input int k);
        return KEY_X0 + k * PITCH;
    endfunction

    // Key whose rectangle contains (xx,yy), or -1.
    function automatic int key_at(input int xx, input int yy);
        if (yy < KEY_Y0 || yy >= KEY_Y0 + KEY_H || xx < KEY_X0) return -1;
        if ((xx - KEY_X0) % PITCH >= KEY_W) return -1;
        if ((xx - KEY_X0) / PITCH >= NUM_KEYS) return -1;
        return (xx - KEY_X0) / PITCH;
    endfunction

    // Pixel-stream monitor: groups contiguous plot cycles into jobs.
    always @(negedge clock) begin
        if (bus.plot === 1'b1) begin
            mx = int'(bus.x);
            my = int'(bus.y);
            if (!in_job) begin
                in_job              = 1'b1;
                cur_job.key         = key_at(mx, my);
                cur_job.colour      = bus.colour;
                cur_job.pixels      = 0;
                cur_job.raster_errs = 0;
                cur_job.first_x     = mx;
                cur_job.first_y     = my;
                cur_job.start_cyc   = cyc;
            end
            if (cur_job.key < 0
                || mx != base_x(cur_job.key) + cur_job.pixels % KEY_W
                || my != KEY_Y0 + cur_job.pixels / KEY_W
                || bus.colour !== cur_job.colour)
                cur_job.raster_errs++;
            if (key_at(mx, my) < 0) stray++;
            fb[my][mx]       = bus.colour;
            cur_job.last_x   = mx;
            cur_job.last_y   = my;
            cur_job.end_cyc  = cyc;
            cur_job.pixels++;
        end else if (in_job) begin
            in_job = 1'b0;
            jobs.push_back(cur_job);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply();
        bus.keys          = mk;
        bus.playback_keys = mp;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_plot(input string tag);
        int n = 0;
        while (bus.plot !== 1'b1 && n < JOB_BUDGET) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_plot_start"}, bus.plot, 1);
    endtask

    task automatic wait_quiet(input string tag);
        int calm = 0;
        int n    = 0;
        while (calm < 8 && n < QUIET_BUDGET) begin
            @(negedge clock);
            n++;
            calm = (bus.busy === 1'b0 && bus.plot === 1'b0) ? calm + 1 : 0;
        end
        check({tag, "_quiet"}, (calm >= 8), 1);
    endtask

    // Wait (bounded) for the next completed job and check it in full.
    task automatic expect_job(input string tag, input int key, input logic [2:0] colour, output job_t j);
        int n = 0;
        while (jobs.size() == 0 && n < JOB_BUDGET) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_arrived"}, (jobs.size() > 0), 1);
        if (jobs.size() > 0) begin
            j = jobs.pop_front();
        end else begin
            j.key = -1; j.colour = 3'bxxx; j.pixels = 0; j.raster_errs = -1;
            j.first_x = -1; j.first_y = -1; j.last_x = -1; j.last_y = -1;
            j.start_cyc = 0; j.end_cyc = 0;
        end
        check({tag, "_key"},     j.key,         key);
        check({tag, "_colour"},  j.colour,      colour);
        check({tag, "_pixels"},  j.pixels,      JOB_PIXELS);
        check({tag, "_raster"},  j.raster_errs, 0);
        check({tag, "_first_x"}, j.first_x,     base_x(key));
        check({tag, "_first_y"}, j.first_y,     KEY_Y0);
        check({tag, "_last_x"},  j.last_x,      base_x(key) + KEY_W - 1);
        check({tag, "_last_y"},  j.last_y,      KEY_Y0 + KEY_H - 1);
    endtask

    // Every rectangle must show the colour of its key's current inputs.
    task automatic check_screen(input string tag);
        for (int k = 0; k < NUM_KEYS; k++) begin
            int bad = 0;
            for (int yy = KEY_Y0; yy < KEY_Y0 + KEY_H; yy++)
                for (int xx = base_x(k); xx < base_x(k) + KEY_W; xx++)
                    if (fb[yy][xx] !== colour_of(mk[k], mp[k])) bad++;
            check($sformatf("%s_screen%0d", tag, k), bad, 0);
        end
    endtask

    task automatic check_port_cleared(input string tag);
        check({tag, "_plot"},   bus.plot,   0);
        check({tag, "_x"},      bus.x,      0);
        check({tag, "_y"},      bus.y,      0);
        check({tag, "_colour"}, bus.colour, 0);
        check({tag, "_busy"},   bus.busy,   0);
    endtask

    initial begin
        job_t j;
        job_t prev;
        int   c0;

        apply();
        reset = 1'b1;
        idle(3);
        check_port_cleared("rst");
        reset = 1'b0;

        // Power-up: every key painted white, in order, back to back.
        for (int k = 0; k < NUM_KEYS; k++) begin
            expect_job($sformatf("boot%0d", k), k, 3'b111, j);
            if (k > 0) check($sformatf("boot%0d_gap", k), j.start_cyc - prev.end_cyc, 3);
            prev = j;
        end
        wait_quiet("boot");
        check("boot_idle_plot", bus.plot, 0);
        check("boot_idle_busy", bus.busy, 0);
        check("boot_no_extra", jobs.size(), 0);
        check_screen("boot");

        // Single key press: latency and geometry of key 2 in red.
        c0 = cyc;
        mk = 4'b0100; apply();
        expect_job("k2red", 2, 3'b100, j);
        check("k2red_latency", j.start_cyc, c0 + 3);
        wait_quiet("k2red");

        // Two keys change during key 1's job: round robin resumes at key 2.
        mk = 4'b0110; apply();
        wait_plot("k1");
        idle(100);
        mk = 4'b0111; mp = 4'b1000; apply();
        expect_job("rr_k1", 1, 3'b100, j);
        prev = j;
        expect_job("rr_k3", 3, 3'b010, j);
        check("rr_k3_gap", j.start_cyc - prev.end_cyc, 3);
        prev = j;
        expect_job("rr_k0", 0, 3'b100, j);
        check("rr_k0_gap", j.start_cyc - prev.end_cyc, 3);
        wait_quiet("rr");
        check_screen("rr");

        // Live plus playback gives yellow.
        mp = 4'b1100; apply();
        expect_job("k2yel", 2, 3'b110, j);
        wait_quiet("k2yel");

        // A one-cycle glitch on key 2 during another job must not cause a job.
        mk = 4'b0101; apply();
        wait_plot("glitch");
        idle(50);
        mk = 4'b0001; apply();
        idle(1);
        mk = 4'b0101; apply();
        expect_job("glitch_k1", 1, 3'b111, j);
        idle(40);
        check("glitch_no_job", jobs.size() + int'(in_job), 0);
        check("glitch_busy", bus.busy, 0);

        // Key 1 changes mid its own job: old colour completes, then repaint.
        mk = 4'b0111; apply();
        wait_plot("self");
        idle(600);
        mp = 4'b1110; apply();
        expect_job("self_old", 1, 3'b100, j);
        prev = j;
        expect_job("self_new", 1, 3'b110, j);
        check("self_gap", j.start_cyc - prev.end_cyc, 3);
        wait_quiet("self");
        check_screen("self");

        // Reset in the middle of key 2's job: port clears, full repaint follows.
        mp = 4'b1010; apply();
        wait_plot("midrst");
        idle(300);
        reset = 1'b1;
        idle(1);
        check_port_cleared("midrst");
        reset = 1'b0;
        idle(1);
        jobs.delete();
        for (int k = 0; k < NUM_KEYS; k++) begin
            expect_job($sformatf("redraw%0d", k), k, colour_of(mk[k], mp[k]), j);
            if (k > 0) check($sformatf("redraw%0d_gap", k), j.start_cyc - prev.end_cyc, 3);
            prev = j;
        end
        wait_quiet("redraw");
        check_screen("redraw");

        // Random activity, including changes that land mid-job.
        for (int it = 0; it < 4; it++) begin
            mk = 4'($urandom()); mp = 4'($urandom()); apply();
            idle($urandom_range(0, 800));
            mk = 4'($urandom()); mp = 4'($urandom()); apply();
            wait_quiet($sformatf("rnd%0d", it));
            while (jobs.size() > 0) begin
                j = jobs.pop_front();
                check($sformatf("rnd%0d_pixels", it), j.pixels, JOB_PIXELS);
                check($sformatf("rnd%0d_raster", it), j.raster_errs, 0);
            end
            check_screen($sformatf("rnd%0d", it));
        end

        check("stray_pixels", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
